// File: rtl/cond_pkg.sv
// cond_pkg: condition codes and flag bit positions shared by the conditional-execution unit
package cond_pkg;
    typedef enum logic [3:0] {
        EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
    } cond_e;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;
endpackage

// File: rtl/cond_if.sv
// cond_if: instruction-in / gated-result-out handshake bundle of the conditional-execution unit
interface cond_if #(parameter int CNT_W = 16);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       cond;
    logic [3:0]       alu_flags;
    logic [1:0]       flag_w;
    logic             reg_write_in;
    logic             mem_write_in;
    logic             pc_src_in;
    logic             out_valid;
    logic             out_ready;
    logic             cond_ex;
    logic             reg_write;
    logic             mem_write;
    logic             pc_src;
    logic [3:0]       flags;
    logic [CNT_W-1:0] skip_count;
    modport master (
        output in_valid, cond, alu_flags, flag_w, reg_write_in, mem_write_in, pc_src_in, out_ready,
        input  in_ready, out_valid, cond_ex, reg_write, mem_write, pc_src, flags, skip_count
    );
    modport slave (
        input  in_valid, cond, alu_flags, flag_w, reg_write_in, mem_write_in, pc_src_in, out_ready,
        output in_ready, out_valid, cond_ex, reg_write, mem_write, pc_src, flags, skip_count
    );
endinterface

// File: rtl/cond_check.sv
// cond_check: evaluates a 4-bit condition field against {N,Z,C,V}
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    logic  n, z, c, v, base;
    cond_e code;
    assign n    = flags[FLAG_N];
    assign z    = flags[FLAG_Z];
    assign c    = flags[FLAG_C];
    assign v    = flags[FLAG_V];
    assign code = cond_e'(cond);
    // even codes give the base test; odd codes are its complement, except the always pair
    always_comb begin
        base = cond[3:1] == 3'd0 ? z :
               cond[3:1] == 3'd1 ? c :
               cond[3:1] == 3'd2 ? n :
               cond[3:1] == 3'd3 ? v :
               cond[3:1] == 3'd4 ? c & ~z :
               cond[3:1] == 3'd5 ? n == v :
               cond[3:1] == 3'd6 ? ~z & (n == v) : 1'b1;
        pass = (code == AL || code == NV) ? 1'b1 : base ^ cond[0];
    end
endmodule

// File: rtl/cond_unit.sv
// cond_unit: flag register plus one-stage valid/ready register gating write/branch strobes by condition
module cond_unit
    import cond_pkg::*;
#(
    parameter int         CNT_W       = 16,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input logic   clk,
    input logic   rst,
    cond_if.slave bus
);
    logic pass, acc;
    assign bus.in_ready = ~bus.out_valid | bus.out_ready;
    assign acc          = bus.in_valid & bus.in_ready;
    cond_check u_check (
        .cond  (bus.cond),
        .flags (bus.flags),
        .pass  (pass)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.cond_ex    <= 1'b0;
            bus.reg_write  <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.pc_src     <= 1'b0;
            bus.flags      <= RESET_FLAGS;
            bus.skip_count <= '0;
        end else if (acc) begin
            bus.out_valid <= 1'b1;
            bus.cond_ex   <= pass;
            bus.reg_write <= bus.reg_write_in & pass;
            bus.mem_write <= bus.mem_write_in & pass;
            bus.pc_src    <= bus.pc_src_in & pass;
            if (pass) begin
                if (bus.flag_w[FLAGW_NZ]) begin
                    bus.flags[FLAG_N] <= bus.alu_flags[FLAG_N];
                    bus.flags[FLAG_Z] <= bus.alu_flags[FLAG_Z];
                end
                if (bus.flag_w[FLAGW_CV]) begin
                    bus.flags[FLAG_C] <= bus.alu_flags[FLAG_C];
                    bus.flags[FLAG_V] <= bus.alu_flags[FLAG_V];
                end
            end else if (~&bus.skip_count) begin
                bus.skip_count <= bus.skip_count + 1'b1;
            end
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed and random stimulus against a cycle-level reference model
module tb_cond_unit;
    localparam int         CNT_W    = 2;
    localparam int         SKIP_MAX = 3;
    localparam logic [3:0] RST_FL   = 4'b0100;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic       m_ov, m_ce, held;
    logic [2:0] m_st;
    logic [3:0] m_flags;
    int         m_skip;
    always #5 clk = ~clk;
    cond_if #(.CNT_W(CNT_W)) bus ();
    cond_unit #(.CNT_W(CNT_W), .RESET_FLAGS(RST_FL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction
    task automatic model_reset();
        m_ov = 0; m_ce = 0; m_st = 0; m_flags = RST_FL; m_skip = 0; held = 0;
    endtask
    // drive one cycle starting just after a rising edge; check and advance the model at the falling edge
    task automatic cyc(input logic r, input logic iv, input logic [3:0] c, input logic [3:0] af,
                       input logic [1:0] fw, input logic [2:0] st, input logic ordy);
        logic ir, p;
        rst = r;
        bus.in_valid = iv; bus.cond = c; bus.alu_flags = af; bus.flag_w = fw;
        {bus.reg_write_in, bus.mem_write_in, bus.pc_src_in} = st;
        bus.out_ready = ordy;
        @(negedge clk);
        ir = !m_ov || ordy;
        check("in_ready", bus.in_ready, ir);
        check("out_valid", bus.out_valid, m_ov);
        check("cond_ex", bus.cond_ex, m_ce);
        check("strobes", {bus.reg_write, bus.mem_write, bus.pc_src}, m_st);
        check("flags", bus.flags, m_flags);
        check("skip_count", bus.skip_count, m_skip);
        held = iv && !ir && !r;
        if (r) model_reset();
        else if (iv && ir) begin
            p = ref_pass(c, m_flags);
            m_ov = 1; m_ce = p; m_st = p ? st : 3'b000;
            if (p) begin
                if (fw[1]) m_flags[3:2] = af[3:2];
                if (fw[0]) m_flags[1:0] = af[1:0];
            end else if (m_skip < SKIP_MAX) m_skip++;
        end else if (ordy) m_ov = 0;
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [3:0] c, af;
        logic [1:0] fw;
        logic [2:0] st;
        logic iv;
        rst = 1;
        bus.in_valid = 0; bus.cond = 0; bus.alu_flags = 0; bus.flag_w = 0;
        bus.reg_write_in = 0; bus.mem_write_in = 0; bus.pc_src_in = 0; bus.out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cyc(0, 0, 0, 0, 0, 0, 0);
        // EQ with Z=1 from reset: passes and loads N,Z only
        cyc(0, 1, 4'd0, 4'b0100, 2'b10, 3'b100, 1);
        check("eq_cond_ex", bus.cond_ex, 1);
        check("eq_reg_write", bus.reg_write, 1);
        check("eq_flags", bus.flags, 4'b0100);
        // NE fails: no flag update, counted as skipped
        cyc(0, 1, 4'd1, 4'b1011, 2'b11, 3'b010, 1);
        check("ne_cond_ex", bus.cond_ex, 0);
        check("ne_mem_write", bus.mem_write, 0);
        check("ne_flags", bus.flags, 4'b0100);
        check("ne_skip", bus.skip_count, 1);
        // back-to-back: GE sees N=V=1 written by the previous instruction
        cyc(0, 1, 4'd14, 4'b1001, 2'b11, 3'b000, 1);
        cyc(0, 1, 4'd10, 4'b0000, 2'b00, 3'b100, 1);
        check("ge_cond_ex", bus.cond_ex, 1);
        // hold three cycles with a failing LT pending, then release
        repeat (3) begin
            cyc(0, 1, 4'd11, 4'b0110, 2'b11, 3'b111, 0);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_flags", bus.flags, 4'b1001);
            check("hold_skip", bus.skip_count, 1);
        end
        cyc(0, 1, 4'd11, 4'b0110, 2'b11, 3'b111, 1);
        check("release_cond_ex", bus.cond_ex, 0);
        check("release_skip", bus.skip_count, 2);
        // every condition against every flag value
        for (int f = 0; f < 16; f++) begin
            cyc(0, 1, 4'd14, 4'(f), 2'b11, 3'b000, 1);
            for (int k = 0; k < 16; k++) begin
                cyc(0, 1, 4'(k), 4'b0000, 2'b00, 3'b111, 1);
                check("sweep_pass", bus.cond_ex, ref_pass(4'(k), 4'(f)));
            end
        end
        check("sweep_skip_sat", bus.skip_count, SKIP_MAX);
        // fresh reset, five failing NE, then reset while holding
        cyc(1, 0, 0, 0, 0, 0, 1);
        repeat (5) cyc(0, 1, 4'd1, 4'b1111, 2'b11, 3'b111, 1);
        check("sat_skip", bus.skip_count, 3);
        check("sat_flags", bus.flags, 4'b0100);
        cyc(1, 1, 4'd14, 4'b1011, 2'b11, 3'b111, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_cond_ex", bus.cond_ex, 0);
        check("rst_flags", bus.flags, RST_FL);
        check("rst_skip", bus.skip_count, 0);
        // random traffic with occasional resets; inputs held while stalled
        c = 0; af = 0; fw = 0; st = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!held) begin
                iv = $urandom_range(0, 3) != 0;
                c  = 4'($urandom);
                af = 4'($urandom);
                fw = 2'($urandom);
                st = 3'($urandom);
            end else iv = 1;
            cyc($urandom_range(0, 99) == 0, iv, c, af, fw, st, $urandom_range(0, 2) != 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution unit that consumes the 4-bit N Z C V flag vector produced by the 32-bit ALU. It holds the architectural flag register and evaluates each instruction's 4-bit condition field against the stored flags. It gates the instruction's register-write, memory-write and PC-select strobes, and updates the flags from the ALU only when the instruction executes. It sits between the decoder/ALU and the register file/PC logic as a one-stage valid/ready pipeline register.

## Interface
Parameters:
- CNT_W, 16, width of the saturating skipped-instruction counter
- RESET_FLAGS, 4'b0000, flag register value after reset, ordered {N,Z,C,V}

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream instruction present
- in_ready  out  1  unit can accept; combinational, = ~out_valid | out_ready
- cond  in  4  instruction condition field, encoding below
- alu_flags  in  4  {N,Z,C,V} from the ALU for this instruction
- flag_w  in  2  bit1: update N,Z; bit0: update C,V
- reg_write_in / mem_write_in / pc_src_in  in  1 each  ungated strobes from the decoder
- out_valid  out  1  registered result valid
- out_ready  in  1  downstream accepts
- cond_ex  out  1  registered: condition passed
- reg_write / mem_write / pc_src  out  1 each  registered strobes ANDed with cond_ex
- flags  out  4  current flag register {N,Z,C,V}
- skip_count  out  CNT_W  accepted instructions whose condition failed, saturating

## Operation
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- The pass value is computed combinationally from cond and the flag register as it stands before the accepting edge. This instruction's own alu_flags never affect its own condition.
- Condition codes:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 1 (treated as always)
- On accept, all of the following happen on the same edge:
  - cond_ex <= pass.
  - Each strobe output <= its _in value & pass.
  - Flag update only if pass is 1: flag_w[1] loads N,Z from alu_flags[3:2]; flag_w[0] loads C,V from alu_flags[1:0]. Bits not enabled hold.
  - skip_count increments by 1 if pass is 0, saturating at all-ones.
- out_valid: set on accept; cleared on emit with no simultaneous accept; stays 1 on simultaneous emit+accept, with outputs replaced.
- Holding (out_valid & ~out_ready): all registered outputs, flags and skip_count are frozen, and in_ready is 0.

## Timing
- Latency 1 cycle from accept to out_valid; throughput 1 per cycle when out_ready is held high.
- Back-to-back: an instruction accepted at cycle t+1 sees flags written by the instruction accepted at t.
- Reset values: out_valid 0, cond_ex 0, reg_write/mem_write/pc_src 0, flags RESET_FLAGS, skip_count 0.
- in_ready is 1 the cycle after reset.
- Reset mid-operation: a held output is discarded, and a concurrent accept is dropped with no flag or counter change.
- in_ready must not depend on in_valid. out_valid must not depend on out_ready.
- Upstream holds inputs stable while in_valid & ~in_ready.

## Structure
- Package cond_pkg holds:
  - cond_e enum of the 16 codes (EQ..AL, NV=4'b1111).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FLAGW_NZ=1 and FLAGW_CV=0.
- One combinational sub-module, cond_check (cond, flags → pass), is instantiated once.
- Flag register, pipeline register and counter live in cond_unit.

## Test plan
- Reset, then accept cond=EQ, flag_w=2'b10, alu_flags=4'b0100, reg_write_in=1. Response: cond_ex=1, reg_write=1, flags=4'b0100 next cycle.
- With flags=4'b0100, accept cond=NE, mem_write_in=1, flag_w=2'b11, alu_flags=4'b1011. Response: cond_ex=0, mem_write=0, flags unchanged at 4'b0100, skip_count=1.
- Back-to-back ADD flag_w=2'b11 alu_flags=4'b1001, then cond=GE (N==V). Response: second instruction cond_ex=1.
- Hold out_ready=0 for 3 cycles with in_valid=1. Response: in_ready=0, and outputs, flags and skip_count stable; release → the pending instruction is accepted the same cycle.
- Sweep all 16 cond × 16 flag values against the table. Response: exact pass match, with 1111 always 1.
- Force skip_count to all-ones via CNT_W=2 and 5 failing conditions, asserting rst while out_valid=1. Response: the counter saturates at 3; after reset all outputs take their reset values and flags=RESET_FLAGS.
